// File: rtl/aircon_compressor_guard_if.sv
// ---------------------------------------------------------------------------
// aircon_compressor_guard_if
// Groups the request/drive signals between SmartAirCon and the compressor guard.
//   turnOn        cooling request (master -> slave)
//   compressorOn  compressor drive (slave -> master)
//   fanOn         fan drive (slave -> master)
//   waiting       request blocked by min-off lockout (slave -> master)
//   startCount    saturating count of compressor starts (slave -> master)
// ---------------------------------------------------------------------------
interface aircon_compressor_guard_if;
  logic       turnOn;
  logic       compressorOn;
  logic       fanOn;
  logic       waiting;
  logic [7:0] startCount;

  modport master (
    output turnOn,
    input  compressorOn,
    input  fanOn,
    input  waiting,
    input  startCount
  );

  modport slave (
    input  turnOn,
    output compressorOn,
    output fanOn,
    output waiting,
    output startCount
  );
endinterface

// File: rtl/aircon_compressor_guard.sv
// ---------------------------------------------------------------------------
// aircon_compressor_guard
// Protects a compressor against short-cycling (minimum on / minimum off
// times), runs the fan ahead of compressor start and after compressor stop,
// and counts compressor starts.
// Ports:
//   clk     in  system clock, rising edge
//   rst     in  asynchronous active-high reset
//   io_bus  slave modport of aircon_compressor_guard_if
//             turnOn (in), compressorOn/fanOn/startCount (registered out),
//             waiting (combinational out)
// ---------------------------------------------------------------------------
module aircon_compressor_guard #(
  parameter int MIN_ON_CYCLES   = 100,
  parameter int MIN_OFF_CYCLES  = 200,
  parameter int FAN_LEAD_CYCLES = 10,
  parameter int FAN_LAG_CYCLES  = 20,
  parameter int CNT_W           = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  aircon_compressor_guard_if.slave     io_bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEAD = 2'd1,
    RUN  = 2'd2,
    LAG  = 2'd3
  } state_t;

  // A phase loaded with N-1 lasts exactly N cycles.
  localparam logic [CNT_W-1:0] LEAD_LOAD = CNT_W'(FAN_LEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(MIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAG_LOAD  = CNT_W'(FAN_LAG_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD  = CNT_W'(MIN_OFF_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_phase_cnt;
  logic [CNT_W-1:0] r_off_cnt;
  logic             r_comp;
  logic             r_fan;
  logic [7:0]       r_start_cnt;
  logic             w_waiting;

  // Drives are set together with the state they belong to, so they are
  // registered yet always match the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_phase_cnt <= '0;
      r_off_cnt   <= OFF_LOAD;
      r_comp      <= 1'b0;
      r_fan       <= 1'b0;
      r_start_cnt <= 8'd0;
    end else begin
      // Lockout timer runs in every state except RUN; a RUN->LAG exit
      // below overrides it with a fresh reload.
      if (r_state != RUN && r_off_cnt != '0) begin
        r_off_cnt <= r_off_cnt - CNT_ONE;
      end

      case (r_state)
        IDLE: begin
          if (io_bus.turnOn && r_off_cnt == '0) begin
            r_state     <= LEAD;
            r_phase_cnt <= LEAD_LOAD;
            r_fan       <= 1'b1;
            r_comp      <= 1'b0;
          end
        end

        LEAD: begin
          if (!io_bus.turnOn) begin
            // Aborted start: compressor never ran, so no lockout reload.
            r_state     <= LAG;
            r_phase_cnt <= LAG_LOAD;
          end else if (r_phase_cnt == '0) begin
            r_state     <= RUN;
            r_phase_cnt <= ON_LOAD;
            r_comp      <= 1'b1;
            if (r_start_cnt != 8'hFF) begin
              r_start_cnt <= r_start_cnt + 8'd1;
            end
          end else begin
            r_phase_cnt <= r_phase_cnt - CNT_ONE;
          end
        end

        RUN: begin
          if (r_phase_cnt != '0) begin
            r_phase_cnt <= r_phase_cnt - CNT_ONE;
          end else if (!io_bus.turnOn) begin
            r_state     <= LAG;
            r_phase_cnt <= LAG_LOAD;
            r_off_cnt   <= OFF_LOAD;
            r_comp      <= 1'b0;
          end
        end

        LAG: begin
          if (r_phase_cnt == '0) begin
            r_state <= IDLE;
            r_fan   <= 1'b0;
          end else begin
            r_phase_cnt <= r_phase_cnt - CNT_ONE;
          end
        end

        default: begin
          r_state <= IDLE;
          r_fan   <= 1'b0;
          r_comp  <= 1'b0;
        end
      endcase
    end
  end

  assign w_waiting = (r_state == IDLE) && io_bus.turnOn && (r_off_cnt != '0);

  assign io_bus.compressorOn = r_comp;
  assign io_bus.fanOn        = r_fan;
  assign io_bus.waiting      = w_waiting;
  assign io_bus.startCount   = r_start_cnt;

endmodule

// File: tb/tb_aircon_compressor_guard.sv
// ---------------------------------------------------------------------------
// tb_aircon_compressor_guard
// Directed bench for aircon_compressor_guard with MIN_ON=8, MIN_OFF=12,
// LEAD=3, LAG=4, CNT_W=8. Edge n is the nth rising edge after reset release;
// outputs are observed 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_aircon_compressor_guard;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   edge_n;

  aircon_compressor_guard_if bus_if ();

  aircon_compressor_guard #(
    .MIN_ON_CYCLES  (8),
    .MIN_OFF_CYCLES (12),
    .FAN_LEAD_CYCLES(3),
    .FAN_LAG_CYCLES (4),
    .CNT_W          (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
    edge_n = edge_n + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.turnOn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    edge_n = 0;
    #1;
    total++; if (bus_if.compressorOn !== 1'b0) begin bad++; $display("FAIL reset_comp got=%b exp=0", bus_if.compressorOn); end
    total++; if (bus_if.fanOn !== 1'b0) begin bad++; $display("FAIL reset_fan got=%b exp=0", bus_if.fanOn); end
    total++; if (bus_if.startCount !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus_if.startCount); end
    total++; if (bus_if.waiting !== 1'b1) begin bad++; $display("FAIL reset_waiting got=%b exp=1", bus_if.waiting); end
    $display("test_reset: comp=%b fan=%b cnt=%0d waiting=%b", bus_if.compressorOn, bus_if.fanOn, bus_if.startCount, bus_if.waiting);
  endtask

  // Request held from reset: lockout through edge 12, fan at 13, comp at 16.
  task automatic test_lockout_start();
    logic ew, ef, ec;
    for (int e = 1; e <= 16; e++) begin
      step();
      ew = (e <= 11);
      ef = (e >= 13);
      ec = (e >= 16);
      total++; if (bus_if.waiting !== ew) begin bad++; $display("FAIL start_waiting edge=%0d got=%b exp=%b", e, bus_if.waiting, ew); end
      total++; if (bus_if.fanOn !== ef) begin bad++; $display("FAIL start_fan edge=%0d got=%b exp=%b", e, bus_if.fanOn, ef); end
      total++; if (bus_if.compressorOn !== ec) begin bad++; $display("FAIL start_comp edge=%0d got=%b exp=%b", e, bus_if.compressorOn, ec); end
    end
    total++; if (bus_if.startCount !== 8'd1) begin bad++; $display("FAIL start_cnt got=%0d exp=1", bus_if.startCount); end
    $display("test_lockout_start: edge=%0d cnt=%0d", edge_n, bus_if.startCount);
  endtask

  // Drop at edge 17: comp holds through 23, falls at 24, fan falls at 28.
  // Re-request seen at edge 26 is ignored in LAG; waiting after edge 28.
  task automatic test_min_on_lag();
    logic ew, ef, ec;
    bus_if.turnOn = 1'b0;
    for (int e = 17; e <= 28; e++) begin
      step();
      ec = (e <= 23);
      ef = (e <= 27);
      ew = (e == 28);
      total++; if (bus_if.compressorOn !== ec) begin bad++; $display("FAIL minon_comp edge=%0d got=%b exp=%b", e, bus_if.compressorOn, ec); end
      total++; if (bus_if.fanOn !== ef) begin bad++; $display("FAIL minon_fan edge=%0d got=%b exp=%b", e, bus_if.fanOn, ef); end
      total++; if (bus_if.waiting !== ew) begin bad++; $display("FAIL minon_waiting edge=%0d got=%b exp=%b", e, bus_if.waiting, ew); end
      if (e == 25) bus_if.turnOn = 1'b1;
    end
    $display("test_min_on_lag: edge=%0d fan=%b comp=%b", edge_n, bus_if.fanOn, bus_if.compressorOn);
  endtask

  // Lockout remainder from edge 28 to 36, fan at 37, comp at 40.
  task automatic test_relock();
    logic ew, ef, ec;
    for (int e = 29; e <= 40; e++) begin
      step();
      ew = (e <= 35);
      ef = (e >= 37);
      ec = (e >= 40);
      total++; if (bus_if.waiting !== ew) begin bad++; $display("FAIL relock_waiting edge=%0d got=%b exp=%b", e, bus_if.waiting, ew); end
      total++; if (bus_if.fanOn !== ef) begin bad++; $display("FAIL relock_fan edge=%0d got=%b exp=%b", e, bus_if.fanOn, ef); end
      total++; if (bus_if.compressorOn !== ec) begin bad++; $display("FAIL relock_comp edge=%0d got=%b exp=%b", e, bus_if.compressorOn, ec); end
    end
    total++; if (bus_if.startCount !== 8'd2) begin bad++; $display("FAIL relock_cnt got=%0d exp=2", bus_if.startCount); end
    $display("test_relock: edge=%0d cnt=%0d", edge_n, bus_if.startCount);
  endtask

  // Abort during LEAD: 4-cycle LAG, no start counted, no lockout afterwards.
  task automatic test_lead_abort();
    bus_if.turnOn = 1'b0;
    repeat (30) step();  // finish RUN, LAG and the lockout
    total++; if (bus_if.fanOn !== 1'b0) begin bad++; $display("FAIL abort_idle_fan got=%b exp=0", bus_if.fanOn); end
    bus_if.turnOn = 1'b1;
    step();  // IDLE -> LEAD
    total++; if (bus_if.fanOn !== 1'b1) begin bad++; $display("FAIL abort_lead_fan got=%b exp=1", bus_if.fanOn); end
    bus_if.turnOn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();  // LEAD -> LAG, then three LAG cycles
      total++; if (bus_if.fanOn !== 1'b1) begin bad++; $display("FAIL abort_lag_fan k=%0d got=%b exp=1", k, bus_if.fanOn); end
      total++; if (bus_if.compressorOn !== 1'b0) begin bad++; $display("FAIL abort_lag_comp k=%0d got=%b exp=0", k, bus_if.compressorOn); end
    end
    step();  // LAG -> IDLE
    total++; if (bus_if.fanOn !== 1'b0) begin bad++; $display("FAIL abort_end_fan got=%b exp=0", bus_if.fanOn); end
    total++; if (bus_if.startCount !== 8'd2) begin bad++; $display("FAIL abort_cnt got=%0d exp=2", bus_if.startCount); end
    bus_if.turnOn = 1'b1;
    #1;
    total++; if (bus_if.waiting !== 1'b0) begin bad++; $display("FAIL abort_no_lockout got=%b exp=0", bus_if.waiting); end
    step();  // IDLE -> LEAD immediately
    total++; if (bus_if.fanOn !== 1'b1) begin bad++; $display("FAIL abort_restart_fan got=%b exp=1", bus_if.fanOn); end
    step(); step();
    total++; if (bus_if.compressorOn !== 1'b0) begin bad++; $display("FAIL abort_restart_comp_early got=%b exp=0", bus_if.compressorOn); end
    step();
    total++; if (bus_if.compressorOn !== 1'b1) begin bad++; $display("FAIL abort_restart_comp got=%b exp=1", bus_if.compressorOn); end
    total++; if (bus_if.startCount !== 8'd3) begin bad++; $display("FAIL abort_restart_cnt got=%0d exp=3", bus_if.startCount); end
    $display("test_lead_abort: cnt=%0d comp=%b", bus_if.startCount, bus_if.compressorOn);
  endtask

  // Reset mid-RUN drops drives without a clock edge and re-arms the lockout.
  task automatic test_reset_mid_run();
    logic ew, ef, ec;
    step(); step();
    total++; if (bus_if.compressorOn !== 1'b1) begin bad++; $display("FAIL rstrun_pre_comp got=%b exp=1", bus_if.compressorOn); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus_if.compressorOn !== 1'b0) begin bad++; $display("FAIL rstrun_comp got=%b exp=0", bus_if.compressorOn); end
    total++; if (bus_if.fanOn !== 1'b0) begin bad++; $display("FAIL rstrun_fan got=%b exp=0", bus_if.fanOn); end
    total++; if (bus_if.startCount !== 8'd0) begin bad++; $display("FAIL rstrun_cnt got=%0d exp=0", bus_if.startCount); end
    @(negedge clk);
    rst = 1'b0;
    edge_n = 0;
    for (int e = 1; e <= 16; e++) begin
      step();
      ew = (e <= 11);
      ef = (e >= 13);
      ec = (e >= 16);
      total++; if (bus_if.waiting !== ew) begin bad++; $display("FAIL rstrun_waiting edge=%0d got=%b exp=%b", e, bus_if.waiting, ew); end
      total++; if (bus_if.fanOn !== ef) begin bad++; $display("FAIL rstrun_fan2 edge=%0d got=%b exp=%b", e, bus_if.fanOn, ef); end
      total++; if (bus_if.compressorOn !== ec) begin bad++; $display("FAIL rstrun_comp2 edge=%0d got=%b exp=%b", e, bus_if.compressorOn, ec); end
    end
    total++; if (bus_if.startCount !== 8'd1) begin bad++; $display("FAIL rstrun_cnt2 got=%0d exp=1", bus_if.startCount); end
    $display("test_reset_mid_run: cnt=%0d", bus_if.startCount);
  endtask

  // 300 more stop/start cycles from startCount=1: saturates at 255.
  task automatic test_saturate();
    int  budget;
    bit  timed_out;
    logic [7:0] exp_cnt;
    timed_out = 1'b0;
    for (int i = 0; i < 300 && !timed_out; i++) begin
      bus_if.turnOn = 1'b0;
      budget = 0;
      while (bus_if.fanOn !== 1'b0 && budget < 60) begin step(); budget++; end
      if (bus_if.fanOn !== 1'b0) begin
        total++; bad++; timed_out = 1'b1;
        $display("FAIL sat_stop_timeout iter=%0d fan=%b exp=0", i, bus_if.fanOn);
      end else begin
        bus_if.turnOn = 1'b1;
        budget = 0;
        while (bus_if.compressorOn !== 1'b1 && budget < 60) begin step(); budget++; end
        if (bus_if.compressorOn !== 1'b1) begin
          total++; bad++; timed_out = 1'b1;
          $display("FAIL sat_start_timeout iter=%0d comp=%b exp=1", i, bus_if.compressorOn);
        end else if (i == 252 || i == 253) begin
          exp_cnt = (i == 252) ? 8'd254 : 8'd255;
          total++; if (bus_if.startCount !== exp_cnt) begin bad++; $display("FAIL sat_cnt iter=%0d got=%0d exp=%0d", i, bus_if.startCount, exp_cnt); end
        end
      end
    end
    total++; if (bus_if.startCount !== 8'd255) begin bad++; $display("FAIL sat_final got=%0d exp=255", bus_if.startCount); end
    $display("test_saturate: cnt=%0d", bus_if.startCount);
  endtask

  initial begin
    total = 0;
    bad = 0;
    edge_n = 0;
    rst = 1'b1;
    bus_if.turnOn = 1'b0;
    test_reset();
    test_lockout_start();
    test_min_on_lag();
    test_relock();
    test_lead_abort();
    test_reset_mid_run();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
